// File: rtl/ccff_ctrl_pkg.sv
// Shared types for the configuration-chain loader: controller states and
// the bit-counter width helper.
package ccff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_VERIFY  = 2'd2,
        ST_RELEASE = 2'd3
    } ctrl_state_t;

    // Wide enough to hold CHAIN_LEN itself, so the counter never wraps.
    function automatic int counterWidth(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit shifter: holds one bitstream word and presents it LSB first
// through a registered output bit with a valid flag.
module ccff_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_advance,
    output logic              o_empty,
    output logic              o_bitValid,
    output logic              o_bit
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] REST_CNT = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_bit;
    logic              r_bitValid;

    // A valid output bit is consumed every cycle; loading goes straight into
    // the output bit so a word taken while the last bit drains adds no bubble.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_data     <= '0;
            r_cnt      <= '0;
            r_bit      <= 1'b0;
            r_bitValid <= 1'b0;
        end else if (i_load) begin
            r_bit      <= i_word[0];
            r_bitValid <= 1'b1;
            r_data     <= i_word >> 1;
            r_cnt      <= REST_CNT;
        end else if (r_bitValid) begin
            if (i_advance && (r_cnt != '0)) begin
                r_bit  <= r_data[0];
                r_data <= r_data >> 1;
                r_cnt  <= r_cnt - CNT_W'(1);
            end else begin
                r_bit      <= 1'b0;
                r_bitValid <= 1'b0;
            end
        end
    end

    assign o_empty    = (r_cnt == '0);
    assign o_bitValid = r_bitValid;
    assign o_bit      = r_bit;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a configuration flip-flop chain from a word stream, verifies it by
// recirculation with a parity check, then releases fabric isolation.
module ccff_chain_loader
    import ccff_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 4,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_shift_en,
    output logic              isol_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CW = counterWidth(CHAIN_LEN);
    localparam logic [CW-1:0] LEN    = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] LEN_M1 = CW'(CHAIN_LEN - 1);

    ctrl_state_t r_state;
    ctrl_state_t w_nextState;

    logic [CW-1:0] r_bitCnt;
    logic          r_parP;
    logic          r_parC;
    logic          r_error;
    logic          r_isolN;

    logic w_serEmpty;
    logic w_serValid;
    logic w_serBit;
    logic w_accept;
    logic w_advance;
    logic w_loadShift;
    logic w_issue;
    logic w_loadLast;
    logic w_verifyLast;
    logic w_cNext;

    // In LOAD the counter tracks bits handed to the output bit, so it reaching
    // CHAIN_LEN means the bit now on the head is the final one.
    assign w_advance    = (r_bitCnt < LEN);
    assign word_ready   = (r_state == ST_LOAD) && w_serEmpty && w_advance;
    assign w_accept     = word_valid && word_ready;
    assign w_loadShift  = (r_state == ST_LOAD) && w_serValid;
    assign w_issue      = w_accept || (w_loadShift && w_advance && !w_serEmpty);
    assign w_loadLast   = w_loadShift && (r_bitCnt == LEN);
    assign w_verifyLast = (r_state == ST_VERIFY) && (r_bitCnt == LEN_M1);
    assign w_cNext      = r_parC ^ ccff_tail;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .i_clk      (prog_clk),
        .i_reset    (prog_reset),
        .i_flush    (w_loadLast),
        .i_load     (w_accept),
        .i_word     (word_data),
        .i_advance  (w_advance),
        .o_empty    (w_serEmpty),
        .o_bitValid (w_serValid),
        .o_bit      (w_serBit)
    );

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_nextState = ST_LOAD;
            ST_LOAD:    if (w_loadLast) w_nextState = ST_VERIFY;
            ST_VERIFY:  if (w_verifyLast) w_nextState = ST_RELEASE;
            ST_RELEASE: w_nextState = ST_IDLE;
            default:    w_nextState = ST_IDLE;
        endcase
    end

    // Verdict is taken on the last VERIFY edge so error/isol_n are already
    // valid while done is high.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_bitCnt <= '0;
            r_parP   <= 1'b0;
            r_parC   <= 1'b0;
            r_error  <= 1'b0;
            r_isolN  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bitCnt <= '0;
                        r_parP   <= 1'b0;
                        r_parC   <= 1'b0;
                        r_error  <= 1'b0;
                        r_isolN  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_loadShift) begin
                        r_parP <= r_parP ^ w_serBit;
                    end
                    if (w_loadLast) begin
                        r_bitCnt <= '0;
                    end else if (w_issue) begin
                        r_bitCnt <= r_bitCnt + CW'(1);
                    end
                end
                ST_VERIFY: begin
                    r_parC <= w_cNext;
                    if (w_verifyLast) begin
                        r_error <= (w_cNext != r_parP);
                        r_isolN <= (w_cNext == r_parP);
                    end else begin
                        r_bitCnt <= r_bitCnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Head follows the tail directly during VERIFY so the loop is exactly
    // CHAIN_LEN long and CHAIN_LEN shifts restore the contents.
    assign ccff_head      = (r_state == ST_VERIFY) ? ccff_tail : w_serBit;
    assign chain_shift_en = w_loadShift || (r_state == ST_VERIFY);
    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_RELEASE);
    assign error          = r_error;
    assign isol_n         = r_isolN;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: three instances (chain lengths 4, 12
// and 1) each driving a behavioural chain model.
module tb_ccff_chain_loader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0] start;
    logic [2:0] wordValid;
    logic [7:0] wordData [3];
    logic [2:0] wordReady;
    logic [2:0] head;
    logic [2:0] shiftEn;
    logic [2:0] isolN;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] error;
    logic       tail0;
    logic       tail1;
    logic       tail2;

    logic [3:0]  chain4  = 4'h0;
    logic [11:0] chain12 = 12'h000;
    logic        chain1  = 1'b0;
    logic        stuck0;

    int checks   = 0;
    int failures = 0;

    ccff_chain_loader #(.CHAIN_LEN(4), .WORD_W(8)) dut4 (
        .prog_clk(clk), .prog_reset(reset), .start(start[0]),
        .word_valid(wordValid[0]), .word_data(wordData[0]), .word_ready(wordReady[0]),
        .ccff_head(head[0]), .ccff_tail(tail0), .chain_shift_en(shiftEn[0]),
        .isol_n(isolN[0]), .busy(busy[0]), .done(done[0]), .error(error[0])
    );

    ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) dut12 (
        .prog_clk(clk), .prog_reset(reset), .start(start[1]),
        .word_valid(wordValid[1]), .word_data(wordData[1]), .word_ready(wordReady[1]),
        .ccff_head(head[1]), .ccff_tail(tail1), .chain_shift_en(shiftEn[1]),
        .isol_n(isolN[1]), .busy(busy[1]), .done(done[1]), .error(error[1])
    );

    ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(8)) dut1 (
        .prog_clk(clk), .prog_reset(reset), .start(start[2]),
        .word_valid(wordValid[2]), .word_data(wordData[2]), .word_ready(wordReady[2]),
        .ccff_head(head[2]), .ccff_tail(tail2), .chain_shift_en(shiftEn[2]),
        .isol_n(isolN[2]), .busy(busy[2]), .done(done[2]), .error(error[2])
    );

    // Chain models: first bit shifted in ends up at the tail (MSB).
    always @(posedge clk) begin
        if (shiftEn[0]) chain4 <= {chain4[2:0], head[0]};
        if (shiftEn[1]) chain12 <= {chain12[10:0], head[1]};
        if (shiftEn[2]) chain1 <= head[2];
    end

    assign tail0 = stuck0 ? 1'b0 : chain4[3];
    assign tail1 = chain12[11];
    assign tail2 = chain1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one load on instance idx; entered and left #1 after a clock edge.
    task automatic applyStimulus(input int idx, input logic [7:0] w0, input logic [7:0] w1,
                                 input int nWords, input int stallCycles, input bit noise,
                                 input int chainLen,
                                 output int totalShifts, output int loadStalls,
                                 output logic [15:0] headBits, output int cycles,
                                 output logic doneSeen, output logic errAtDone,
                                 output logic isolAtDone);
        int accepted = 0;
        int withheld = 0;
        totalShifts = 0;
        loadStalls  = 0;
        headBits    = '0;
        cycles      = 0;
        doneSeen    = 1'b0;
        errAtDone   = 1'b0;
        isolAtDone  = 1'b0;
        if (noise) begin
            wordValid[idx] = 1'b1;
            wordData[idx]  = 8'hFF;
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            wordValid[idx] = 1'b0;
        end
        start[idx] = 1'b1;
        @(posedge clk);
        #1;
        start[idx] = 1'b0;
        while (!doneSeen && cycles < 200) begin
            cycles++;
            if (shiftEn[idx]) begin
                if (totalShifts < chainLen) headBits[totalShifts] = head[idx];
                totalShifts++;
            end else if (totalShifts > 0 && totalShifts < chainLen) begin
                loadStalls++;
            end
            if (done[idx]) begin
                doneSeen   = 1'b1;
                errAtDone  = error[idx];
                isolAtDone = isolN[idx];
            end
            wordValid[idx] = 1'b0;
            if (accepted < nWords) begin
                if (accepted == 1 && withheld < stallCycles) begin
                    if (wordReady[idx]) withheld++;
                end else begin
                    wordValid[idx] = 1'b1;
                    wordData[idx]  = (accepted == 0) ? w0 : w1;
                    if (wordReady[idx]) accepted++;
                end
            end
            start[idx] = (noise && totalShifts >= chainLen && !doneSeen);
            @(posedge clk);
            #1;
        end
        start[idx]     = 1'b0;
        wordValid[idx] = 1'b0;
    endtask

    initial begin
        int          shifts;
        int          stalls;
        int          cyc;
        logic [15:0] bits;
        logic        dn;
        logic        er;
        logic        iso;

        reset     = 1'b1;
        start     = '0;
        wordValid = '0;
        stuck0    = 1'b0;
        for (int i = 0; i < 3; i++) wordData[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 3'b000);
        checkOutput("rst_done", done, 3'b000);
        checkOutput("rst_error", error, 3'b000);
        checkOutput("rst_isol", isolN, 3'b000);
        checkOutput("rst_shift", shiftEn, 3'b000);
        checkOutput("rst_ready", wordReady, 3'b000);
        checkOutput("rst_head", head, 3'b000);
        reset = 1'b0;

        $display("[TB] nominal load, CHAIN_LEN=4, word 0xA5");
        applyStimulus(0, 8'hA5, 8'h00, 1, 0, 1'b0, 4, shifts, stalls, bits, cyc, dn, er, iso);
        checkOutput("nom_head", bits[3:0], 4'h5);
        checkOutput("nom_shifts", shifts, 8);
        checkOutput("nom_stalls", stalls, 0);
        checkOutput("nom_cycles", cyc, 10);
        checkOutput("nom_done", dn, 1);
        checkOutput("nom_error", er, 0);
        checkOutput("nom_isol", iso, 1);
        checkOutput("nom_chain", chain4, 4'hA);
        checkOutput("nom_idle_busy", busy[0], 0);
        checkOutput("nom_idle_done", done[0], 0);
        checkOutput("nom_idle_isol", isolN[0], 1);

        $display("[TB] ignored start in VERIFY and word_valid in IDLE");
        applyStimulus(0, 8'hA5, 8'h00, 1, 0, 1'b1, 4, shifts, stalls, bits, cyc, dn, er, iso);
        checkOutput("noise_cycles", cyc, 10);
        checkOutput("noise_shifts", shifts, 8);
        checkOutput("noise_head", bits[3:0], 4'h5);
        checkOutput("noise_isol", iso, 1);
        checkOutput("noise_busy", busy[0], 0);

        $display("[TB] tail stuck at 0, word 0x07");
        stuck0 = 1'b1;
        applyStimulus(0, 8'h07, 8'h00, 1, 0, 1'b0, 4, shifts, stalls, bits, cyc, dn, er, iso);
        stuck0 = 1'b0;
        checkOutput("fault_head", bits[3:0], 4'h7);
        checkOutput("fault_done", dn, 1);
        checkOutput("fault_error", er, 1);
        checkOutput("fault_isol", iso, 0);
        checkOutput("fault_sticky", error[0], 1);
        checkOutput("fault_isol_idle", isolN[0], 0);

        $display("[TB] reset in the middle of LOAD");
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        checkOutput("restart_clr_err", error[0], 0);
        wordValid[0] = 1'b1;
        wordData[0]  = 8'hA5;
        @(posedge clk);
        #1;
        wordValid[0] = 1'b0;
        checkOutput("mid_shift1", shiftEn[0], 1);
        @(posedge clk);
        #1;
        checkOutput("mid_shift2", shiftEn[0], 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("mid_busy", busy[0], 0);
        checkOutput("mid_done", done[0], 0);
        checkOutput("mid_error", error[0], 0);
        checkOutput("mid_isol", isolN[0], 0);
        checkOutput("mid_shift", shiftEn[0], 0);
        checkOutput("mid_ready", wordReady[0], 0);
        checkOutput("mid_head", head[0], 0);
        applyStimulus(0, 8'hA5, 8'h00, 1, 0, 1'b0, 4, shifts, stalls, bits, cyc, dn, er, iso);
        checkOutput("rec_head", bits[3:0], 4'h5);
        checkOutput("rec_cycles", cyc, 10);
        checkOutput("rec_error", er, 0);
        checkOutput("rec_isol", iso, 1);
        checkOutput("rec_chain", chain4, 4'hA);

        $display("[TB] stall, CHAIN_LEN=12, words 0x3C then 0xF9");
        applyStimulus(1, 8'h3C, 8'hF9, 2, 3, 1'b0, 12, shifts, stalls, bits, cyc, dn, er, iso);
        checkOutput("stall_head", bits[11:0], 12'h93C);
        checkOutput("stall_shifts", shifts, 24);
        checkOutput("stall_zero", stalls, 3);
        checkOutput("stall_cycles", cyc, 29);
        checkOutput("stall_done", dn, 1);
        checkOutput("stall_error", er, 0);
        checkOutput("stall_isol", iso, 1);
        checkOutput("stall_chain", chain12, 12'h3C9);

        $display("[TB] single-bit chain, word 0x01");
        applyStimulus(2, 8'h01, 8'h00, 1, 0, 1'b0, 1, shifts, stalls, bits, cyc, dn, er, iso);
        checkOutput("one_head", bits[0], 1);
        checkOutput("one_shifts", shifts, 2);
        checkOutput("one_cycles", cyc, 4);
        checkOutput("one_done", dn, 1);
        checkOutput("one_error", er, 0);
        checkOutput("one_isol", iso, 1);
        checkOutput("one_chain", chain1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
